// File: rtl/adc_mux_scan_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : adc_mux_scan_defs                                            |
// | Purpose   : Shared definitions for the ADC mux scanner: channel width,   |
// |             EOC synchronizer depth, FSM state encoding and the           |
// |             round-robin channel search helper.                           |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package adc_mux_scan_defs;

    localparam int c_CH_W           = 3;
    localparam int c_NUM_CH         = 1 << c_CH_W;
    localparam int c_EOC_SYNC_DEPTH = 2;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SELECT   = 3'd1;
    localparam logic [2:0] c_ST_CONVST   = 3'd2;
    localparam logic [2:0] c_ST_WAIT_EOC = 3'd3;
    localparam logic [2:0] c_ST_SHIFT    = 3'd4;
    localparam logic [2:0] c_ST_OUTPUT   = 3'd5;
    localparam logic [2:0] c_ST_NEXT     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = c_ST_IDLE,
        S_SELECT   = c_ST_SELECT,
        S_CONVST   = c_ST_CONVST,
        S_WAIT_EOC = c_ST_WAIT_EOC,
        S_SHIFT    = c_ST_SHIFT,
        S_OUTPUT   = c_ST_OUTPUT,
        S_NEXT     = c_ST_NEXT
    } state_t;

    // First set bit of mask at or after start, wrapping past the top channel.
    // Returns start when the mask is empty; callers never act on that case.
    function automatic logic [c_CH_W-1:0] find_ch(
        input logic [c_NUM_CH-1:0] mask,
        input logic [c_CH_W-1:0]   start
    );
        logic [c_CH_W-1:0] idx;
        find_ch = start;
        // Walk from the farthest offset down so the nearest hit wins.
        for (int i = c_NUM_CH - 1; i >= 0; i--) begin
            idx = start + c_CH_W'(i);
            if (mask[idx]) begin
                find_ch = idx;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_mux_scan_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : adc_mux_scan_if                                              |
// | Purpose   : Sample stream from the scanner to its consumer.              |
// |   sample_data  [DATA_WIDTH] conversion result                            |
// |   sample_ch    [3]          mux channel of sample_data                   |
// |   sample_valid              sample available, held until accepted        |
// |   sample_ready              consumer accepts sample                      |
// |   modport master : scanner side, modport slave : consumer side           |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface adc_mux_scan_if #(
    parameter int DATA_WIDTH = 16
);
    import adc_mux_scan_defs::*;

    logic [DATA_WIDTH-1:0] sample_data;
    logic [c_CH_W-1:0]     sample_ch;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/adc_spi_shift.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : adc_spi_shift                                                |
// | Purpose   : CPOL=0 SPI shifter, DATA_WIDTH bits, MSB first. A start      |
// |             pulse presents the first sdi bit at once; sclk rises every   |
// |             2*CLK_DIV cycles starting CLK_DIV cycles after start. sdo is |
// |             captured on the rising cycle, sdi advances on the falling    |
// |             cycle. done pulses one cycle after the last falling edge.    |
// | Ports     : clk_250mhz, rst_250mhz, start, done, rx_data,                |
// |             adc_sclk, adc_sdi (out), adc_sdo (in)                        |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module adc_spi_shift #(
    parameter int                    CLK_DIV    = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] SDI_WORD   = '0
) (
    input  logic                  clk_250mhz,
    input  logic                  rst_250mhz,
    input  logic                  start,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  adc_sclk,
    output logic                  adc_sdi,
    input  logic                  adc_sdo
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_BIT_W = $clog2(DATA_WIDTH);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

    logic                  r_active;
    logic [c_DIV_W-1:0]    r_div;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic                  r_sclk;
    logic                  r_sdi;
    logic                  r_done;

    always_ff @(posedge clk_250mhz) begin
        if (rst_250mhz) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_sclk   <= 1'b0;
            r_sdi    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_active <= 1'b1;
                r_div    <= '0;
                r_bit    <= '0;
                r_sclk   <= 1'b0;
                r_sdi    <= SDI_WORD[DATA_WIDTH-1];
                r_tx     <= SDI_WORD << 1;
            end else if (r_active) begin
                if (r_div == c_DIV_LAST) begin
                    r_div <= '0;
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[DATA_WIDTH-2:0], adc_sdo};
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit == c_BIT_LAST) begin
                            r_active <= 1'b0;
                            r_done   <= 1'b1;
                            r_sdi    <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_sdi <= r_tx[DATA_WIDTH-1];
                            r_tx  <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign rx_data  = r_rx;
    assign adc_sclk = r_sclk;
    assign adc_sdi  = r_sdi;

endmodule
`default_nettype wire

// File: rtl/adc_mux_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : adc_mux_scan                                                 |
// | Purpose   : Round-robin scanner for the analog mux and serial ADC:       |
// |             select, settle, convst, wait EOC, SPI read, hand off sample. |
// | Ports     : clk_250mhz, rst_250mhz (sync, active high), enable, ch_mask, |
// |             mux_s, adc_convst, adc_eoc (async, active low), adc_cs,      |
// |             adc_sclk, adc_sdi, adc_sdo, smp (sample stream, master),     |
// |             busy, timeout_err                                            |
// | Macro     : ADC_MUX_SCAN_TIMEOUT_EN - EOC watchdog of TIMEOUT_CYCLES;    |
// |             without it WAIT_EOC waits forever and timeout_err is 0.      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module adc_mux_scan
    import adc_mux_scan_defs::*;
#(
    parameter int                    CLK_DIV        = 8,
    parameter int                    SETTLE_CYCLES  = 250,
    parameter int                    CONVST_CYCLES  = 4,
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] SDI_WORD       = '0,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_250mhz,
    input  logic                rst_250mhz,
    input  logic                enable,
    input  logic [c_NUM_CH-1:0] ch_mask,
    output logic [c_CH_W-1:0]   mux_s,
    output logic                adc_convst,
    input  logic                adc_eoc,
    output logic                adc_cs,
    output logic                adc_sclk,
    output logic                adc_sdi,
    input  logic                adc_sdo,
    adc_mux_scan_if.master      smp,
    output logic                busy,
    output logic                timeout_err
);

    localparam int c_CNT_MAX0 = (SETTLE_CYCLES > CONVST_CYCLES) ? SETTLE_CYCLES : CONVST_CYCLES;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > TIMEOUT_CYCLES) ? c_CNT_MAX0 : TIMEOUT_CYCLES;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);

    state_t                      r_state, w_state_nxt;
    logic [c_CNT_W-1:0]          r_cnt, w_cnt_nxt;
    logic [c_CH_W-1:0]           r_mux, w_mux_nxt;
    logic [c_CH_W-1:0]           r_ptr, w_ptr_nxt;
    logic                        r_valid, w_valid_nxt;
    logic [DATA_WIDTH-1:0]       r_data, w_data_nxt;
    logic [c_CH_W-1:0]           r_ch, w_ch_nxt;
    logic                        r_convst, r_cs_n, r_busy;
    logic [c_EOC_SYNC_DEPTH-1:0] r_eoc_sync;
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
    logic                        r_err, w_err_nxt;
`endif

    logic                  w_eoc_n;
    logic                  w_run;
    logic [c_CH_W-1:0]     w_first_ch;
    logic [c_CH_W-1:0]     w_next_ch;
    logic                  w_spi_start;
    logic                  w_spi_done;
    logic [DATA_WIDTH-1:0] w_rx;

    assign w_eoc_n    = r_eoc_sync[c_EOC_SYNC_DEPTH-1];
    assign w_run      = enable && (ch_mask != '0);
    assign w_first_ch = find_ch(ch_mask, r_ptr);
    assign w_next_ch  = find_ch(ch_mask, r_mux + c_CH_W'(1));

    adc_spi_shift #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (DATA_WIDTH),
        .SDI_WORD   (SDI_WORD)
    ) u_spi (
        .clk_250mhz (clk_250mhz),
        .rst_250mhz (rst_250mhz),
        .start      (w_spi_start),
        .done       (w_spi_done),
        .rx_data    (w_rx),
        .adc_sclk   (adc_sclk),
        .adc_sdi    (adc_sdi),
        .adc_sdo    (adc_sdo)
    );

    // Pin-level outputs are registered from the next state so they change on
    // the same edge as the state and never glitch on a state decode.
    always_ff @(posedge clk_250mhz) begin
        if (rst_250mhz) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mux      <= '0;
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_ch       <= '0;
            r_convst   <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_eoc_sync <= '1;
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mux      <= w_mux_nxt;
            r_ptr      <= w_ptr_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_ch       <= w_ch_nxt;
            r_convst   <= (w_state_nxt == S_CONVST);
            r_cs_n     <= (w_state_nxt != S_SHIFT);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_eoc_sync <= {r_eoc_sync[c_EOC_SYNC_DEPTH-2:0], adc_eoc};
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
            r_err      <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_mux_nxt   = r_mux;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_ch_nxt    = r_ch;
        w_spi_start = 1'b0;
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
        w_err_nxt   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_run) begin
                    w_state_nxt = S_SELECT;
                    w_mux_nxt   = w_first_ch;
                    w_ptr_nxt   = w_first_ch;
                end
            end
            S_SELECT: begin
                if (r_cnt == c_CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nxt = S_CONVST;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CONVST: begin
                if (r_cnt == c_CNT_W'(CONVST_CYCLES - 1)) begin
                    w_state_nxt = S_WAIT_EOC;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_EOC: begin
                if (!w_eoc_n) begin
                    w_state_nxt = S_SHIFT;
                    w_spi_start = 1'b1;
                end
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
                else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_NEXT;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_SHIFT: begin
                if (w_spi_done) begin
                    w_state_nxt = S_OUTPUT;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_rx;
                    w_ch_nxt    = r_mux;
                end
            end
            S_OUTPUT: begin
                if (smp.sample_ready) begin
                    w_state_nxt = S_NEXT;
                    w_valid_nxt = 1'b0;
                end
            end
            S_NEXT: begin
                // An empty mask leaves the pointer where it was so a later
                // restart resumes from the same place.
                if (ch_mask != '0) begin
                    w_ptr_nxt = w_next_ch;
                end
                if (w_run) begin
                    w_state_nxt = S_SELECT;
                    w_mux_nxt   = w_next_ch;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mux_s            = r_mux;
    assign adc_convst       = r_convst;
    assign adc_cs           = r_cs_n;
    assign busy             = r_busy;
    assign smp.sample_valid = r_valid;
    assign smp.sample_data  = r_data;
    assign smp.sample_ch    = r_ch;
`ifdef ADC_MUX_SCAN_TIMEOUT_EN
    assign timeout_err      = r_err;
`else
    assign timeout_err      = 1'b0;
`endif

endmodule
`default_nettype wire
